// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
//   Two-requester round-robin arbiter in front of a single fixed-latency
//   sprite ROM. A granted request issues one registered ROM read. A tag
//   pipeline of depth ROM_LAT records which requester each read belongs to.
//   When the tag reaches the end of the pipeline, rom_data is captured into
//   that requester's response register.
//
// Parameters
//   ROM_LAT    1..4, cycles from rom_rd to valid rom_data
//   KEY_COLOR  transparency key colour (only with SPRITE_KEY_EN)
//
// Optional feature macro: SPRITE_KEY_EN adds the rsp1_key / rsp2_key outputs.
//
// Ports
//   Clk, Reset            clock, synchronous active-high reset
//   flush                 drops every in-flight read (vblank)
//   reqN_valid/addr/ready requester N fetch handshake (ready is combinational)
//   rom_rd, rom_addr      registered ROM read strobe and address
//   rom_data              ROM word, valid ROM_LAT cycles after rom_rd
//   rspN_valid, rspN_data one-cycle response pulse and held RGB word
//   rspN_key              captured word equals KEY_COLOR (SPRITE_KEY_EN only)
module sprite_rom_arbiter #(
    parameter int unsigned ROM_LAT = 2
`ifdef SPRITE_KEY_EN
    ,
    parameter logic [23:0] KEY_COLOR = 24'hFF00FF
`endif
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        flush,
    input  logic        req1_valid,
    input  logic [18:0] req1_addr,
    output logic        req1_ready,
    input  logic        req2_valid,
    input  logic [18:0] req2_addr,
    output logic        req2_ready,
    output logic        rom_rd,
    output logic [18:0] rom_addr,
    input  logic [23:0] rom_data,
    output logic        rsp1_valid,
    output logic [23:0] rsp1_data,
    output logic        rsp2_valid,
    output logic [23:0] rsp2_data
`ifdef SPRITE_KEY_EN
    ,
    output logic        rsp1_key,
    output logic        rsp2_key
`endif
);

    typedef enum logic {
        GRANT_1 = 1'b0,
        GRANT_2 = 1'b1
    } grant_e;

    grant_e             last_grant;
    grant_e             rd_id;
    grant_e             grant_id;
    grant_e             tag_id [ROM_LAT];
    logic [ROM_LAT-1:0] tag_v;
    logic [18:0]        grant_addr;
    logic               xfer;
    logic               cap1;
    logic               cap2;
    logic               rsp1_q;
    logic               rsp2_q;

    // Round-robin grant: under contention the requester not granted last wins.
    always_comb begin
        req1_ready = 1'b0;
        req2_ready = 1'b0;
        if (!Reset && !flush) begin
            if (req1_valid && (!req2_valid || last_grant == GRANT_2))
                req1_ready = 1'b1;
            else if (req2_valid)
                req2_ready = 1'b1;
        end
    end

    assign xfer       = req1_ready | req2_ready;
    assign grant_id   = req1_ready ? GRANT_1 : GRANT_2;
    assign grant_addr = req1_ready ? req1_addr : req2_addr;

    // Issue stage: rom_addr and last_grant change only on a transfer.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_rd     <= 1'b0;
            rom_addr   <= '0;
            rd_id      <= GRANT_1;
            last_grant <= GRANT_2;
        end else begin
            rom_rd <= xfer;
            if (xfer) begin
                rom_addr   <= grant_addr;
                rd_id      <= grant_id;
                last_grant <= grant_id;
            end
        end
    end

    // Tag valid bits; flush also kills the read currently on rom_rd.
    always_ff @(posedge Clk) begin
        if (Reset || flush) begin
            tag_v <= '0;
        end else begin
            tag_v[0] <= rom_rd;
            for (int unsigned i = 1; i < ROM_LAT; i++)
                tag_v[i] <= tag_v[i-1];
        end
    end

    // Tag ids need no reset; they are only consulted when the matching valid bit is set.
    always_ff @(posedge Clk) begin
        tag_id[0] <= rd_id;
        for (int unsigned i = 1; i < ROM_LAT; i++)
            tag_id[i] <= tag_id[i-1];
    end

    assign cap1 = tag_v[ROM_LAT-1] && !flush && (tag_id[ROM_LAT-1] == GRANT_1);
    assign cap2 = tag_v[ROM_LAT-1] && !flush && (tag_id[ROM_LAT-1] == GRANT_2);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rsp1_q    <= 1'b0;
            rsp2_q    <= 1'b0;
            rsp1_data <= '0;
            rsp2_data <= '0;
`ifdef SPRITE_KEY_EN
            rsp1_key  <= 1'b0;
            rsp2_key  <= 1'b0;
`endif
        end else begin
            rsp1_q <= cap1;
            rsp2_q <= cap2;
            if (cap1) begin
                rsp1_data <= rom_data;
`ifdef SPRITE_KEY_EN
                rsp1_key  <= (rom_data == KEY_COLOR);
`endif
            end
            if (cap2) begin
                rsp2_data <= rom_data;
`ifdef SPRITE_KEY_EN
                rsp2_key  <= (rom_data == KEY_COLOR);
`endif
            end
        end
    end

    // A pulse already registered for a pre-flush read must not appear
    // during the flush cycle, so the pulse is masked by flush.
    assign rsp1_valid = rsp1_q & ~flush;
    assign rsp2_valid = rsp2_q & ~flush;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed testbench for sprite_rom_arbiter.
// The main instance uses ROM_LAT=2. Two extra instances use ROM_LAT=1 and ROM_LAT=4.
// Each instance has its own ROM model that returns rom_word(addr) with that instance's latency.
module tb_sprite_rom_arbiter;

    logic        Clk;
    logic        rst;
    logic        flush;
    logic        r1v, r2v;
    logic [18:0] r1a, r2a;
    logic        r1r, r2r;
    logic        rom_rd;
    logic [18:0] rom_addr;
    logic [23:0] rom_data;
    logic        s1v, s2v;
    logic [23:0] s1d, s2d;
    logic        k1, k2;

    logic        zero;
    logic [18:0] zaddr;
    logic        lv;
    logic [18:0] la;
    logic        l1_r1r, l1_r2r, l1_rd, l1_s1v, l1_s2v, l1_k1, l1_k2;
    logic        l4_r1r, l4_r2r, l4_rd, l4_s1v, l4_s2v, l4_k1, l4_k2;
    logic [18:0] l1_addr, l4_addr;
    logic [23:0] l1_data, l4_data, l1_s1d, l1_s2d, l4_s1d, l4_s2d;

    logic [18:0] pm [2];
    logic [18:0] p1 [1];
    logic [18:0] p4 [4];

    int n_checks;
    int n_fail;

    function automatic logic [23:0] rom_word(input logic [18:0] a);
        case (a)
            19'h70001: rom_word = 24'hFF00FF;
            19'h70002: rom_word = 24'hFF00FE;
            default:   rom_word = {5'b10101, a};
        endcase
    endfunction

    sprite_rom_arbiter #(.ROM_LAT(2)) dut (
        .Clk(Clk), .Reset(rst), .flush(flush),
        .req1_valid(r1v), .req1_addr(r1a), .req1_ready(r1r),
        .req2_valid(r2v), .req2_addr(r2a), .req2_ready(r2r),
        .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
        .rsp1_valid(s1v), .rsp1_data(s1d), .rsp2_valid(s2v), .rsp2_data(s2d)
`ifdef SPRITE_KEY_EN
        , .rsp1_key(k1), .rsp2_key(k2)
`endif
    );

    sprite_rom_arbiter #(.ROM_LAT(1)) dut_l1 (
        .Clk(Clk), .Reset(rst), .flush(zero),
        .req1_valid(lv), .req1_addr(la), .req1_ready(l1_r1r),
        .req2_valid(zero), .req2_addr(zaddr), .req2_ready(l1_r2r),
        .rom_rd(l1_rd), .rom_addr(l1_addr), .rom_data(l1_data),
        .rsp1_valid(l1_s1v), .rsp1_data(l1_s1d), .rsp2_valid(l1_s2v), .rsp2_data(l1_s2d)
`ifdef SPRITE_KEY_EN
        , .rsp1_key(l1_k1), .rsp2_key(l1_k2)
`endif
    );

    sprite_rom_arbiter #(.ROM_LAT(4)) dut_l4 (
        .Clk(Clk), .Reset(rst), .flush(zero),
        .req1_valid(lv), .req1_addr(la), .req1_ready(l4_r1r),
        .req2_valid(zero), .req2_addr(zaddr), .req2_ready(l4_r2r),
        .rom_rd(l4_rd), .rom_addr(l4_addr), .rom_data(l4_data),
        .rsp1_valid(l4_s1v), .rsp1_data(l4_s1d), .rsp2_valid(l4_s2v), .rsp2_data(l4_s2d)
`ifdef SPRITE_KEY_EN
        , .rsp1_key(l4_k1), .rsp2_key(l4_k2)
`endif
    );

    // ROM models: the address shifts down a delay line, and data appears ROM_LAT cycles after rom_rd.
    always @(posedge Clk) begin
        pm[0] <= rom_addr;
        pm[1] <= pm[0];
        p1[0] <= l1_addr;
        p4[0] <= l4_addr;
        for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
    end
    assign rom_data = rom_word(pm[1]);
    assign l1_data  = rom_word(p1[0]);
    assign l4_data  = rom_word(p4[3]);

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; r1v = 1'b1; r1a = 19'h1; r2v = 1'b1; r2a = 19'h2;
        tick();
        tick();
        #1;
        n_checks++; if (r1r !== 1'b0 || r2r !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b%b want 00", r1r, r2r); end
        n_checks++; if (rom_rd !== 1'b0 || rom_addr !== 19'h0) begin n_fail++; $display("FAIL reset_rom got rd=%b addr=%h want 0/0", rom_rd, rom_addr); end
        n_checks++; if (s1v !== 1'b0 || s2v !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b%b want 00", s1v, s2v); end
        n_checks++; if (s1d !== 24'h0 || s2d !== 24'h0) begin n_fail++; $display("FAIL reset_rsp_data got %h %h want 0 0", s1d, s2d); end
        n_checks++; if (l1_rd !== 1'b0 || l4_rd !== 1'b0 || l1_s1v !== 1'b0 || l4_s1v !== 1'b0) begin n_fail++; $display("FAIL reset_aux got %b%b%b%b want 0000", l1_rd, l4_rd, l1_s1v, l4_s1v); end
`ifdef SPRITE_KEY_EN
        n_checks++; if (k1 !== 1'b0 || k2 !== 1'b0) begin n_fail++; $display("FAIL reset_key got %b%b want 00", k1, k2); end
`endif
        rst = 1'b0; r1v = 1'b0; r2v = 1'b0;
        tick();
    endtask

    // Single player-1 read at cycle H: rom_rd at H+1, rsp1_valid at H+4.
    task automatic test_single();
        r1v = 1'b1; r1a = 19'h00010; #1;
        n_checks++; if (r1r !== 1'b1 || r2r !== 1'b0) begin n_fail++; $display("FAIL single_ready got %b%b want 10", r1r, r2r); end
        tick();
        r1v = 1'b0; #1;
        n_checks++; if (rom_rd !== 1'b1 || rom_addr !== 19'h00010) begin n_fail++; $display("FAIL single_rom got rd=%b addr=%h want 1/00010", rom_rd, rom_addr); end
        for (int k = 2; k <= 5; k++) begin
            tick(); #1;
            n_checks++; if (s1v !== (k == 4) || s2v !== 1'b0) begin n_fail++; $display("FAIL single_rsp_valid k=%0d got %b%b want %b0", k, s1v, s2v, (k == 4)); end
            if (k >= 4) begin
                n_checks++; if (s1d !== rom_word(19'h00010)) begin n_fail++; $display("FAIL single_rsp_data k=%0d got %h want %h", k, s1d, rom_word(19'h00010)); end
            end
        end
    endtask

    // Both players request continuously for 4 cycles right after reset.
    task automatic test_contention();
        logic [18:0] ea;
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            r1v = (c < 4); r2v = (c < 4); r1a = 19'h100; r2a = 19'h200; #1;
            n_checks++; if (r1r !== (c < 4 && c % 2 == 0) || r2r !== (c < 4 && c % 2 == 1)) begin n_fail++; $display("FAIL cont_grant c=%0d got %b%b", c, r1r, r2r); end
            ea = (c % 2 == 1) ? 19'h100 : 19'h200;
            if (c >= 1) begin
                n_checks++; if (rom_rd !== (c <= 4) || rom_addr !== ((c <= 4) ? ea : 19'h200)) begin n_fail++; $display("FAIL cont_rom c=%0d got rd=%b addr=%h", c, rom_rd, rom_addr); end
            end
            n_checks++; if (s1v !== (c == 4 || c == 6) || s2v !== (c == 5 || c == 7)) begin n_fail++; $display("FAIL cont_rsp c=%0d got %b%b", c, s1v, s2v); end
            if (c == 4 || c == 6) begin
                n_checks++; if (s1d !== rom_word(19'h100)) begin n_fail++; $display("FAIL cont_rsp1_data got %h want %h", s1d, rom_word(19'h100)); end
            end
            if (c == 5 || c == 7) begin
                n_checks++; if (s2d !== rom_word(19'h200)) begin n_fail++; $display("FAIL cont_rsp2_data got %h want %h", s2d, rom_word(19'h200)); end
            end
            tick();
        end
    endtask

    // Three reads at f=0..2 and flush at f=4 while player 2 waits; player 2 is taken at f=5.
    task automatic test_flush();
        logic [18:0] ea;
        for (int f = 0; f <= 10; f++) begin
            r1v = (f < 3); r1a = 19'h00500 + 19'(f);
            flush = (f == 4);
            r2v = (f == 4 || f == 5); r2a = 19'h00333; #1;
            n_checks++; if (r1r !== (f < 3) || r2r !== (f == 5)) begin n_fail++; $display("FAIL flush_ready f=%0d got %b%b", f, r1r, r2r); end
            if (f >= 1) begin
                ea = (f <= 3) ? 19'h00500 + 19'(f - 1) : ((f <= 5) ? 19'h00502 : 19'h00333);
                n_checks++; if (rom_rd !== ((f >= 1 && f <= 3) || f == 6) || rom_addr !== ea) begin n_fail++; $display("FAIL flush_rom f=%0d got rd=%b addr=%h want addr %h", f, rom_rd, rom_addr, ea); end
            end
            n_checks++; if (s1v !== 1'b0 || s2v !== (f == 9)) begin n_fail++; $display("FAIL flush_rsp f=%0d got %b%b want 0%b", f, s1v, s2v, (f == 9)); end
            if (f >= 4) begin
                n_checks++; if (s1d !== rom_word(19'h00500)) begin n_fail++; $display("FAIL flush_rsp1_data f=%0d got %h want %h", f, s1d, rom_word(19'h00500)); end
            end
            if (f == 9) begin
                n_checks++; if (s2d !== rom_word(19'h00333)) begin n_fail++; $display("FAIL flush_rsp2_data got %h want %h", s2d, rom_word(19'h00333)); end
            end
            tick();
        end
        flush = 1'b0; r1v = 1'b0; r2v = 1'b0;
    endtask

    // Player-1 read at r0, Reset at r2 (one cycle after rom_rd), contention at r4.
    task automatic test_reset_midflight();
        r1v = 1'b1; r1a = 19'h00444; #1;
        n_checks++; if (r1r !== 1'b1) begin n_fail++; $display("FAIL rmf_ready0 got %b want 1", r1r); end
        tick();
        r1v = 1'b0; #1;
        n_checks++; if (rom_rd !== 1'b1 || rom_addr !== 19'h00444) begin n_fail++; $display("FAIL rmf_rom got rd=%b addr=%h want 1/00444", rom_rd, rom_addr); end
        tick();
        rst = 1'b1; r1v = 1'b1; #1;
        n_checks++; if (r1r !== 1'b0 || r2r !== 1'b0) begin n_fail++; $display("FAIL rmf_ready_in_reset got %b%b want 00", r1r, r2r); end
        tick();
        rst = 1'b0; r1v = 1'b0; #1;
        n_checks++; if (rom_rd !== 1'b0 || rom_addr !== 19'h0 || s1d !== 24'h0 || s2d !== 24'h0) begin n_fail++; $display("FAIL rmf_cleared got rd=%b addr=%h d1=%h d2=%h want all 0", rom_rd, rom_addr, s1d, s2d); end
        for (int r = 3; r <= 9; r++) begin
            if (r > 3) begin
                r1v = (r == 4); r2v = (r == 4); r1a = 19'h00001; r2a = 19'h00002; #1;
            end
            if (r == 4) begin
                n_checks++; if (r1r !== 1'b1 || r2r !== 1'b0) begin n_fail++; $display("FAIL rmf_first_grant got %b%b want 10", r1r, r2r); end
            end
            n_checks++; if (s1v !== (r == 8) || s2v !== 1'b0) begin n_fail++; $display("FAIL rmf_rsp r=%0d got %b%b want %b0", r, s1v, s2v, (r == 8)); end
            tick();
        end
        r1v = 1'b0; r2v = 1'b0;
    endtask

    // The same single read on the ROM_LAT=1 and ROM_LAT=4 instances: pulses at H+3 and H+6.
    task automatic test_latency();
        lv = 1'b1; la = 19'h00010; #1;
        n_checks++; if (l1_r1r !== 1'b1 || l4_r1r !== 1'b1) begin n_fail++; $display("FAIL lat_ready got %b%b want 11", l1_r1r, l4_r1r); end
        for (int k = 1; k <= 7; k++) begin
            tick();
            lv = 1'b0; #1;
            n_checks++; if (l1_s1v !== (k == 3) || l4_s1v !== (k == 6)) begin n_fail++; $display("FAIL lat_rsp k=%0d got l1=%b l4=%b", k, l1_s1v, l4_s1v); end
            if (k == 3) begin
                n_checks++; if (l1_s1d !== rom_word(19'h00010)) begin n_fail++; $display("FAIL lat1_data got %h want %h", l1_s1d, rom_word(19'h00010)); end
            end
            if (k == 6) begin
                n_checks++; if (l4_s1d !== rom_word(19'h00010)) begin n_fail++; $display("FAIL lat4_data got %h want %h", l4_s1d, rom_word(19'h00010)); end
            end
        end
    endtask

`ifdef SPRITE_KEY_EN
    task automatic test_key();
        for (int k = 0; k <= 6; k++) begin
            r2v = (k < 2); r2a = (k == 0) ? 19'h70001 : 19'h70002; #1;
            if (k == 4) begin
                n_checks++; if (s2v !== 1'b1 || s2d !== 24'hFF00FF || k2 !== 1'b1) begin n_fail++; $display("FAIL key_match got v=%b d=%h key=%b want 1 ff00ff 1", s2v, s2d, k2); end
            end
            if (k == 5) begin
                n_checks++; if (s2v !== 1'b1 || s2d !== 24'hFF00FE || k2 !== 1'b0) begin n_fail++; $display("FAIL key_nomatch got v=%b d=%h key=%b want 1 ff00fe 0", s2v, s2d, k2); end
            end
            tick();
        end
        r2v = 1'b0;
    endtask
`endif

    initial begin
        n_checks = 0; n_fail = 0;
        zero = 1'b0; zaddr = '0; lv = 1'b0; la = '0;
        flush = 1'b0; rst = 1'b1;
        r1v = 1'b0; r2v = 1'b0; r1a = '0; r2a = '0;
        test_reset();
        test_single();
        test_contention();
        test_flush();
        test_reset_midflight();
        test_latency();
`ifdef SPRITE_KEY_EN
        test_key();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
